// File: rtl/pe_pkg.sv
// Shared definitions for the parameterised processing element: mode encodings
// and the unsigned saturation helper used on every result path.
package pe_pkg;

    typedef enum logic [1:0] {
        MODE_CONV = 2'd0,
        MODE_DOT  = 2'd1,
        MODE_LOAD = 2'd2,
        MODE_IDLE = 2'd3
    } pe_mode_e;

    // Wide enough for any legal accumulator; callers zero-extend into it.
    localparam int SAT_W = 64;

    // Clamp an unsigned value to the largest data_w-bit code.
    function automatic logic [SAT_W-1:0] sat(input logic [SAT_W-1:0] val,
                                             input int unsigned      data_w);
        logic [SAT_W-1:0] max_val;
        max_val = (SAT_W'(1) << data_w) - SAT_W'(1);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/pe_param_if.sv
// Data/control bundle of one processing element; the master drives samples and
// mode, the slave (the PE) returns forwarded copies and the saturated result.
interface pe_param_if #(parameter int DATA_W = 8);

    logic              activate;
    logic [1:0]        mode_i;
    logic [DATA_W-1:0] pe_in;
    logic [DATA_W-1:0] pe_filter;
    logic [DATA_W-1:0] pe_in_o;
    logic              activate_o;
    logic [DATA_W-1:0] pe_out;
    logic              out_valid;

    modport master (
        output activate, mode_i, pe_in, pe_filter,
        input  pe_in_o, activate_o, pe_out, out_valid
    );

    modport slave (
        input  activate, mode_i, pe_in, pe_filter,
        output pe_in_o, activate_o, pe_out, out_valid
    );

endinterface

// File: rtl/pe_dot_unit.sv
// Combinational TAPS-wide multiply-add of window against filter, evaluated at
// full accumulator width so no partial sum can overflow.
module pe_dot_unit #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 3,
    parameter int ACC_W  = 20
) (
    input  logic [TAPS-1:0][DATA_W-1:0] window,
    input  logic [TAPS-1:0][DATA_W-1:0] filter,
    output logic [ACC_W-1:0]            sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < TAPS; i++) begin
            sum = sum + ACC_W'(window[i]) * ACC_W'(filter[i]);
        end
    end

endmodule

// File: rtl/pe_param.sv
// Parameterised PE: loads filter taps, then runs a sliding-window convolution
// or a streamed dot product; results are saturated to DATA_W and registered.
module pe_param
    import pe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int TAPS   = 3,
    parameter int ACC_W  = 20
) (
    input  logic         clk,
    input  logic         rst,
    pe_param_if.slave    bus
);

    localparam int IDX_W = $clog2(TAPS);
    localparam int CNT_W = $clog2(TAPS + 1);

    typedef logic [TAPS-1:0][DATA_W-1:0] taps_t;

    taps_t              filter_q, filter_d;
    taps_t              window_q, window_d;
    taps_t              window_shift;
    logic [IDX_W-1:0]   load_idx_q, load_idx_d, load_eff;
    logic [IDX_W-1:0]   dot_idx_q, dot_idx_d, dot_eff;
    logic [CNT_W-1:0]   fill_q, fill_d, fill_eff;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_eff;
    logic [ACC_W-1:0]   conv_sum, dot_prod, dot_sum;
    pe_mode_e           mode_q, mode_d, mode_in;
    logic               switching;
    logic [DATA_W-1:0]  pe_out_q, pe_out_d, pe_in_o_q;
    logic               out_valid_q, out_valid_d, activate_o_q;

    assign mode_in   = pe_mode_e'(bus.mode_i);
    assign switching = (mode_in != mode_q);

    // A mode change restarts every sequence counter without touching taps/window.
    assign load_eff = switching ? '0 : load_idx_q;
    assign dot_eff  = switching ? '0 : dot_idx_q;
    assign fill_eff = switching ? '0 : fill_q;
    assign acc_eff  = switching ? '0 : acc_q;

    // Newest sample enters at the top; index 0 stays the oldest.
    assign window_shift = {bus.pe_in, window_q[TAPS-1:1]};

    pe_dot_unit #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS),
        .ACC_W  (ACC_W)
    ) u_dot_unit (
        .window (window_shift),
        .filter (filter_q),
        .sum    (conv_sum)
    );

    assign dot_prod = ACC_W'(bus.pe_in) * ACC_W'(filter_q[dot_eff]);
    assign dot_sum  = acc_eff + dot_prod;

    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path through the case statements can leave a value stored (a latch).
        filter_d    = filter_q;
        window_d    = window_q;
        load_idx_d  = load_idx_q;
        dot_idx_d   = dot_idx_q;
        fill_d      = fill_q;
        acc_d       = acc_q;
        mode_d      = mode_q;
        pe_out_d    = pe_out_q;
        out_valid_d = 1'b0;

        if (bus.activate) begin
            mode_d = mode_in;
            if (mode_in != MODE_IDLE) begin
                load_idx_d = load_eff;
                dot_idx_d  = dot_eff;
                fill_d     = fill_eff;
                acc_d      = acc_eff;
            end

            unique case (mode_in)
                MODE_LOAD: begin
                    filter_d[load_eff] = bus.pe_filter;
                    load_idx_d = (load_eff == IDX_W'(TAPS - 1)) ? '0 : load_eff + IDX_W'(1);
                end
                MODE_CONV: begin
                    window_d = window_shift;
                    fill_d   = (fill_eff == CNT_W'(TAPS)) ? fill_eff : fill_eff + CNT_W'(1);
                    if (fill_d == CNT_W'(TAPS)) begin
                        pe_out_d    = DATA_W'(sat(SAT_W'(conv_sum), DATA_W));
                        out_valid_d = 1'b1;
                    end
                end
                MODE_DOT: begin
                    if (dot_eff == IDX_W'(TAPS - 1)) begin
                        pe_out_d    = DATA_W'(sat(SAT_W'(dot_sum), DATA_W));
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        dot_idx_d   = '0;
                    end else begin
                        acc_d     = dot_sum;
                        dot_idx_d = dot_eff + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: tap and window storage is cleared here because a DOT right
            // after reset must see zero coefficients, not stale data.
            filter_q     <= '0;
            window_q     <= '0;
            load_idx_q   <= '0;
            dot_idx_q    <= '0;
            fill_q       <= '0;
            acc_q        <= '0;
            mode_q       <= MODE_IDLE;
            pe_out_q     <= '0;
            out_valid_q  <= 1'b0;
            pe_in_o_q    <= '0;
            activate_o_q <= 1'b0;
        end else begin
            filter_q     <= filter_d;
            window_q     <= window_d;
            load_idx_q   <= load_idx_d;
            dot_idx_q    <= dot_idx_d;
            fill_q       <= fill_d;
            acc_q        <= acc_d;
            mode_q       <= mode_d;
            pe_out_q     <= pe_out_d;
            out_valid_q  <= out_valid_d;
            pe_in_o_q    <= bus.pe_in;
            activate_o_q <= bus.activate;
        end
    end

    assign bus.pe_out     = pe_out_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.pe_in_o    = pe_in_o_q;
    assign bus.activate_o = activate_o_q;

endmodule

// File: tb/tb_pe_param.sv
// Self-checking bench: directed scenarios plus sticky-mode random traffic on the
// default PE against a queue-based model, and a directed sweep on a 4/5/12 PE.
module tb_pe_param;
    import pe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_param_if #(.DATA_W(8)) bus ();
    pe_param_if #(.DATA_W(4)) sw_bus ();

    pe_param #(.DATA_W(8), .TAPS(3), .ACC_W(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pe_param #(.DATA_W(4), .TAPS(5), .ACC_W(12)) dut_sw (
        .clk (clk),
        .rst (rst),
        .bus (sw_bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model for the default PE: conv_hist holds the last three CONV
    // samples ever seen, runs count activations since the last mode change.
    localparam int M_TAPS = 3;
    localparam int M_MAX  = 255;
    int m_filter [M_TAPS];
    int conv_hist[$];
    int dot_in[$];
    int conv_run, load_cnt, m_mode;
    int exp_out, exp_valid, exp_in_o, exp_act_o;

    task automatic model_reset();
        foreach (m_filter[i]) m_filter[i] = 0;
        conv_hist = {0, 0, 0};
        dot_in.delete();
        conv_run = 0; load_cnt = 0; m_mode = 3;
        exp_out = 0; exp_valid = 0; exp_in_o = 0; exp_act_o = 0;
    endtask

    task automatic model_step(input bit act, input int mode, input int pin, input int pfilt);
        int sum;
        exp_in_o  = pin;
        exp_act_o = act;
        exp_valid = 0;
        if (act) begin
            if (mode != m_mode) begin
                conv_run = 0; load_cnt = 0; dot_in.delete();
            end
            m_mode = mode;
            case (mode)
                2: begin
                    m_filter[load_cnt % M_TAPS] = pfilt;
                    load_cnt++;
                end
                0: begin
                    conv_hist.push_back(pin);
                    void'(conv_hist.pop_front());
                    conv_run++;
                    if (conv_run >= M_TAPS) begin
                        sum = 0;
                        for (int i = 0; i < M_TAPS; i++) sum += conv_hist[i] * m_filter[i];
                        exp_out = (sum > M_MAX) ? M_MAX : sum;
                        exp_valid = 1;
                    end
                end
                1: begin
                    dot_in.push_back(pin);
                    if (dot_in.size() == M_TAPS) begin
                        sum = 0;
                        for (int i = 0; i < M_TAPS; i++) sum += dot_in[i] * m_filter[i];
                        exp_out = (sum > M_MAX) ? M_MAX : sum;
                        exp_valid = 1;
                        dot_in.delete();
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic cycle(input bit act, input int mode, input int pin, input int pfilt);
        bus.activate  = act;
        bus.mode_i    = 2'(mode);
        bus.pe_in     = 8'(pin);
        bus.pe_filter = 8'(pfilt);
        model_step(act, mode, pin, pfilt);
        @(posedge clk);
        #1;
        cyc++;
        check($sformatf("c%0d_out_valid", cyc), 32'(bus.out_valid), 32'(exp_valid));
        check($sformatf("c%0d_pe_out", cyc), 32'(bus.pe_out), 32'(exp_out));
        check($sformatf("c%0d_pe_in_o", cyc), 32'(bus.pe_in_o), 32'(exp_in_o));
        check($sformatf("c%0d_activate_o", cyc), 32'(bus.activate_o), 32'(exp_act_o));
    endtask

    // Reset is asserted with an active DOT request to show it takes priority.
    task automatic do_reset();
        rst = 1'b1;
        bus.activate  = 1'b1;
        bus.mode_i    = MODE_DOT;
        bus.pe_in     = 8'($urandom_range(1, 255));
        bus.pe_filter = 8'($urandom_range(1, 255));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_pe_out", 32'(bus.pe_out), 32'd0);
        check("rst_pe_in_o", 32'(bus.pe_in_o), 32'd0);
        check("rst_activate_o", 32'(bus.activate_o), 32'd0);
        check("rst_sw_pe_out", 32'(sw_bus.pe_out), 32'd0);
    endtask

    task automatic sw_cycle(input int mode, input int pin, input int pfilt);
        sw_bus.activate  = 1'b1;
        sw_bus.mode_i    = 2'(mode);
        sw_bus.pe_in     = 4'(pin);
        sw_bus.pe_filter = 4'(pfilt);
        @(posedge clk);
        #1;
    endtask

    int vcount;
    int r_mode;

    initial begin
        rst = 1'b1;
        bus.activate = 1'b0; bus.mode_i = MODE_IDLE; bus.pe_in = '0; bus.pe_filter = '0;
        sw_bus.activate = 1'b0; sw_bus.mode_i = MODE_IDLE; sw_bus.pe_in = '0; sw_bus.pe_filter = '0;
        do_reset();

        // Load 1,2,3 then convolve 1..6: results 14,20,26,32 on inputs 3..6.
        for (int i = 1; i <= 3; i++) cycle(1, MODE_LOAD, $urandom_range(0, 255), i);
        for (int i = 1; i <= 6; i++) begin
            cycle(1, MODE_CONV, i, $urandom_range(0, 255));
            if (i >= 3) check($sformatf("conv_result_%0d", i), 32'(bus.pe_out), 32'(14 + 6 * (i - 3)));
        end

        // Dot product of 1..6 with the same taps: exactly two results, 14 then 32.
        vcount = 0;
        for (int i = 1; i <= 6; i++) begin
            cycle(1, MODE_DOT, i, 0);
            vcount += int'(bus.out_valid);
            if (i == 3) check("dot_first", 32'(bus.pe_out), 32'd14);
        end
        check("dot_last", 32'(bus.pe_out), 32'd32);
        check("dot_valid_count", 32'(vcount), 32'd2);

        // Saturation: 10*10 + 10*11 + 10*12 = 330 clamps to 255.
        cycle(1, MODE_LOAD, 0, 10);
        cycle(1, MODE_LOAD, 0, 11);
        cycle(1, MODE_LOAD, 0, 12);
        for (int i = 0; i < 3; i++) cycle(1, MODE_DOT, 10, 0);
        check("sat_out", 32'(bus.pe_out), 32'd255);
        check("sat_valid", 32'(bus.out_valid), 32'd1);

        // Activate gating in the middle of a CONV fill.
        for (int i = 1; i <= 3; i++) cycle(1, MODE_LOAD, 0, i);
        cycle(1, MODE_CONV, 1, 0);
        cycle(1, MODE_CONV, 2, 0);
        cycle(0, MODE_CONV, 200, 7);
        cycle(0, MODE_DOT, 99, 9);
        cycle(1, MODE_CONV, 3, 0);
        check("gate_resume", 32'(bus.pe_out), 32'd14);
        cycle(1, MODE_CONV, 4, 0);
        check("gate_next", 32'(bus.pe_out), 32'd20);

        // CONV -> DOT after two samples restarts counting; then reset mid-DOT.
        cycle(1, MODE_CONV, 5, 0);
        cycle(1, MODE_CONV, 6, 0);
        cycle(1, MODE_DOT, 1, 0);
        cycle(1, MODE_DOT, 2, 0);
        check("switch_no_early", 32'(bus.out_valid), 32'd0);
        cycle(1, MODE_DOT, 3, 0);
        check("switch_dot", 32'(bus.pe_out), 32'd14);
        cycle(1, MODE_DOT, 4, 0);
        do_reset();
        for (int i = 7; i <= 9; i++) cycle(1, MODE_DOT, i, 0);
        check("rst_dot_valid", 32'(bus.out_valid), 32'd1);
        check("rst_dot_zero", 32'(bus.pe_out), 32'd0);

        // Random traffic with sticky modes so CONV/DOT sequences complete.
        r_mode = MODE_LOAD;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) r_mode = int'($urandom_range(0, 3));
            cycle($urandom_range(0, 4) != 0, r_mode, $urandom_range(0, 255), $urandom_range(0, 255));
        end

        // Parameter sweep: five taps of 1, CONV inputs of 3 -> 15 on the 5th input.
        bus.activate = 1'b0;
        for (int i = 0; i < 5; i++) sw_cycle(MODE_LOAD, 0, 1);
        check("sw_load_valid", 32'(sw_bus.out_valid), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            sw_cycle(MODE_CONV, 3, 0);
            check($sformatf("sw_conv_valid_%0d", i), 32'(sw_bus.out_valid), 32'(i == 5));
        end
        check("sw_conv_out", 32'(sw_bus.pe_out), 32'd15);
        check("sw_in_o", 32'(sw_bus.pe_in_o), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_param.md
PE_PARAM -- requirements
Module: pe_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the width of input, filter and output data.
REQ-002 The block SHALL have parameter TAPS, default 3, giving the number of filter taps (legal range 2..16).
REQ-003 The block SHALL have parameter ACC_W, default 20, giving the internal accumulator width; legal values satisfy ACC_W >= 2*DATA_W + clog2(TAPS).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port activate, input, 1 bit: enables data processing this cycle.
REQ-007 The block SHALL have port mode_i, input, 2 bits: operation select (0 CONV, 1 DOT, 2 LOAD, 3 IDLE).
REQ-008 The block SHALL have port pe_in, input, DATA_W bits: unsigned input sample.
REQ-009 The block SHALL have port pe_filter, input, DATA_W bits: unsigned filter coefficient, used in LOAD.
REQ-010 The block SHALL have port pe_in_o, output, DATA_W bits: pe_in forwarded to the neighbour PE.
REQ-011 The block SHALL have port activate_o, output, 1 bit: activate forwarded to the neighbour PE.
REQ-012 The block SHALL have port pe_out, output, DATA_W bits: saturated result.
REQ-013 The block SHALL have port out_valid, output, 1 bit: pe_out holds a new result this cycle.

Function
REQ-014 pe_in_o and activate_o SHALL be registered copies of pe_in and activate: 1-cycle latency, updated every cycle regardless of mode and activate.
REQ-015 The block SHALL hold filter[0..TAPS-1], window[0..TAPS-1] (window[0] oldest), a load index, a fill count (0..TAPS), a dot index, an ACC_W accumulator and mode_q (registered mode_i).
REQ-016 When activate=0, all internal state SHALL be frozen and out_valid SHALL be 0 that cycle.
REQ-017 When activate=1 and mode_i != mode_q, the load index, fill count, dot index and accumulator SHALL be treated as zero for this cycle's processing; filter and window contents SHALL be retained.
REQ-018 LOAD (activate=1): filter[load_idx] <= pe_filter; load_idx increments and wraps from TAPS-1 to 0; out_valid=0.
REQ-019 CONV (activate=1): the window shifts (window[TAPS-1] <= pe_in, window[i] <= window[i+1]), and the fill count increments, saturating at TAPS.
REQ-020 CONV: when the post-increment fill count equals TAPS, pe_out SHALL become sat(sum over i of new window[i]*filter[i]) and out_valid=1 on the next cycle; otherwise out_valid=0.
REQ-021 DOT (activate=1): the product pe_in*filter[dot_idx] SHALL be added to the accumulator; when dot_idx=TAPS-1, pe_out <= sat(acc + product), out_valid=1, and acc and dot_idx clear to 0; otherwise dot_idx increments.
REQ-022 IDLE: all state SHALL be held except mode_q; out_valid=0.
REQ-023 sat() SHALL clamp an unsigned ACC_W value to 2^DATA_W-1 if it exceeds that value; products and sums SHALL be computed at full ACC_W width with no intermediate overflow.
REQ-024 pe_out SHALL hold its last value whenever out_valid=0.
REQ-025 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-026 On rst=1 at a clock edge: pe_out, pe_in_o, out_valid, activate_o, all filter and window entries, counters and the accumulator SHALL become 0, and mode_q SHALL become 3 (IDLE); rst SHALL take priority over all other inputs, including mid-operation.

Structure
REQ-027 Mode encodings (MODE_CONV, MODE_DOT, MODE_LOAD, MODE_IDLE) and the saturation helper SHALL live in shared package pe_pkg.
REQ-028 The TAPS-wide multiply-add of REQ-020 SHALL be a combinational sub-module pe_dot_unit (parameters DATA_W, TAPS, ACC_W).

Verification
REQ-029 Test LOAD plus CONV (defaults): load 1,2,3, then CONV inputs 1..6 -> out_valid pulses on cycles 3..6 of CONV with pe_out 14, 20, 26, 32.
REQ-030 Test DOT: filter 1,2,3, DOT inputs 1..6 -> pe_out 14 after the 3rd input and 32 after the 6th; out_valid high exactly twice.
REQ-031 Test saturation: load 10,11,12, DOT inputs 10,10,10 -> pe_out=255 (raw 330), out_valid=1.
REQ-032 Test activate gating and forwarding: drop activate for 2 cycles mid-CONV -> no out_valid, window frozen, result continues correctly; pe_in_o/activate_o track the inputs with 1 cycle delay throughout.
REQ-033 Test mode switch and reset: CONV → DOT after 2 inputs restarts counts (first DOT result after 3 DOT inputs); assert rst mid-DOT -> all outputs 0 next cycle, filters cleared (a subsequent DOT yields 0).
REQ-034 Test parameter sweep: DATA_W=4, TAPS=5, ACC_W=12 -> load all 1s, CONV inputs of 3 -> pe_out=15 (raw 15), out_valid after the 5th input.
